// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: redirect/stall controls, instruction-memory port and IF/ID register outputs.
// master = fetch_stage side, slave = surrounding pipeline / memory side.
interface fetch_stage_if;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] pc;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc_plus2;
    logic        if_id_valid;
    logic        fetch_halted;

    modport master (
        input  stall, branch_taken, branch_target, imem_data,
        output imem_addr, pc, if_id_instr, if_id_pc_plus2, if_id_valid, fetch_halted
    );

    modport slave (
        output stall, branch_taken, branch_target, imem_data,
        input  imem_addr, pc, if_id_instr, if_id_pc_plus2, if_id_valid, fetch_halted
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, stall hold,
// branch flush and HLT freeze (priority: flush > stall > halted > fetch).
module fetch_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);
    typedef enum logic {FETCH, HALTED} state_t;

    state_t      state;
    logic [15:0] pc_q;
    logic [15:0] instr_q;
    logic [15:0] pc_plus2_q;
    logic        valid_q;
    logic [15:0] pc_next_seq;

    assign pc_next_seq = pc_q + 16'd2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            pc_plus2_q <= '0;
            valid_q    <= 1'b0;
        end else if (bus.branch_taken) begin
            // Flush also cancels an HLT that was fetched in the branch shadow.
            state      <= FETCH;
            pc_q       <= bus.branch_target & 16'hFFFE;
            instr_q    <= '0;
            pc_plus2_q <= '0;
            valid_q    <= 1'b0;
        end else if (!bus.stall) begin
            case (state)
                HALTED: begin
                    instr_q <= '0;
                    valid_q <= 1'b0;
                end
                default: begin
                    instr_q    <= bus.imem_data;
                    pc_plus2_q <= pc_next_seq;
                    valid_q    <= 1'b1;
                    if (bus.imem_data[15:12] == HLT_OPCODE) begin
                        state <= HALTED;
                    end else begin
                        pc_q <= pc_next_seq;
                    end
                end
            endcase
        end
    end

    assign bus.imem_addr      = {pc_q[15:1], 1'b0};
    assign bus.pc             = pc_q;
    assign bus.if_id_instr    = instr_q;
    assign bus.if_id_pc_plus2 = pc_plus2_q;
    assign bus.if_id_valid    = valid_q;
    assign bus.fetch_halted   = (state == HALTED);
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then randomized
// stall/branch/reset traffic against a behavioural model of the fetch rules.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic [15:0] mem [32768];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // behavioural model state
    logic [15:0] m_pc, m_instr, m_pp2;
    logic        m_valid, m_halt;

    fetch_stage_if bus ();

    assign bus.stall         = stall;
    assign bus.branch_taken  = branch_taken;
    assign bus.branch_target = branch_target;
    assign bus.imem_data     = mem[bus.imem_addr[15:1]];

    fetch_stage #(
        .RESET_PC  (16'h0000),
        .HLT_OPCODE(4'hF)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %04h expected %04h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 16'h0000; m_instr = 16'h0000; m_pp2 = 16'h0000;
        m_valid = 1'b0; m_halt = 1'b0;
    endtask

    task automatic model_edge();
        logic [15:0] w;
        if (!rst_n) begin
            model_reset();
        end else if (branch_taken) begin
            m_pc = {branch_target[15:1], 1'b0};
            m_instr = 16'h0000; m_pp2 = 16'h0000; m_valid = 1'b0; m_halt = 1'b0;
        end else if (stall) begin
            // everything holds
        end else if (m_halt) begin
            m_valid = 1'b0; m_instr = 16'h0000;
        end else begin
            w = mem[m_pc / 2];
            m_instr = w;
            m_pp2   = m_pc + 16'd2;
            m_valid = 1'b1;
            if (w[15:12] == 4'hF) m_halt = 1'b1;
            else                  m_pc = m_pc + 16'd2;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},    bus.pc, m_pc);
        check({tag, ".addr"},  bus.imem_addr, m_pc & 16'hFFFE);
        check({tag, ".instr"}, bus.if_id_instr, m_instr);
        check({tag, ".pp2"},   bus.if_id_pc_plus2, m_pp2);
        check({tag, ".valid"}, {15'd0, bus.if_id_valid}, {15'd0, m_valid});
        check({tag, ".halt"},  {15'd0, bus.fetch_halted}, {15'd0, m_halt});
    endtask

    // one rising edge with the currently driven inputs, then compare #1 later
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic set_in(input logic s, input logic b, input logic [15:0] t);
        stall = s; branch_taken = b; branch_target = t;
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom_range(0, 16'hEFFF));
        mem[0] = 16'h1234; mem[1] = 16'h2345; mem[2] = 16'h3456; mem[3] = 16'h4567;
        mem[4] = 16'hF000; mem[8] = 16'h5A5A; mem[16'h20] = 16'h6789; mem[16'h7FFF] = 16'h0ABC;

        #2;
        model_reset();
        check_all("reset");
        rst_n = 1'b1;

        // sequential fetch
        tick("seq1");
        check("seq1.instr_k", bus.if_id_instr, 16'h1234);
        tick("seq2");
        check("seq2.pc_k", bus.pc, 16'h0004);

        // stall for two cycles at pc = 4
        set_in(1'b1, 1'b0, 16'h0000);
        tick("stall1");
        tick("stall2");
        check("stall.instr_k", bus.if_id_instr, 16'h2345);
        set_in(1'b0, 1'b0, 16'h0000);
        tick("unstall");
        check("unstall.pp2_k", bus.if_id_pc_plus2, 16'h0006);

        // branch wins over simultaneous stall, odd target bit dropped
        set_in(1'b1, 1'b1, 16'h0041);
        tick("brstall");
        check("brstall.pc_k", bus.pc, 16'h0040);
        set_in(1'b0, 1'b0, 16'h0000);
        tick("br_fetch");
        check("br_fetch.instr_k", bus.if_id_instr, 16'h6789);

        // halt at address 8
        set_in(1'b0, 1'b1, 16'h0008);
        tick("to8");
        set_in(1'b0, 1'b0, 16'h0000);
        tick("hlt");
        check("hlt.pp2_k", bus.if_id_pc_plus2, 16'h000A);
        check("hlt.halt_k", {15'd0, bus.fetch_halted}, 16'd1);
        for (int i = 0; i < 5; i++) tick("bubble");
        set_in(1'b1, 1'b0, 16'h0000);
        tick("hlt_stall");
        set_in(1'b0, 1'b1, 16'h0010);
        tick("unhalt");
        set_in(1'b0, 1'b0, 16'h0000);
        tick("resume");

        // HLT in branch shadow
        set_in(1'b0, 1'b1, 16'h0008);
        tick("to8b");
        set_in(1'b0, 1'b0, 16'h0000);
        tick("hltb");
        set_in(1'b0, 1'b1, 16'h0010);
        tick("shadow");
        check("shadow.pc_k", bus.pc, 16'h0010);
        set_in(1'b0, 1'b0, 16'h0000);
        tick("resume2");

        // wrap-around
        set_in(1'b0, 1'b1, 16'hFFFE);
        tick("toFFFE");
        set_in(1'b0, 1'b0, 16'h0000);
        tick("wrap");
        check("wrap.pc_k", bus.pc, 16'h0000);
        check("wrap.pp2_k", bus.if_id_pc_plus2, 16'h0000);

        // async reset between edges
        tick("pre_rst");
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all("async_rst");
        #1 rst_n = 1'b1;
        tick("post_rst");

        // randomized traffic; ~1/16 of memory words decode as HLT
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        for (int n = 0; n < 600; n++) begin
            set_in($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                   16'($urandom_range(0, 16'h00FF)));
            if ($urandom_range(0, 49) == 0) begin
                #2 rst_n = 1'b0;
                #1 model_reset();
                check_all("rnd_rst");
                #1 rst_n = 1'b1;
            end
            tick("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
